// File: rtl/jtcus30_pkg.sv
// Shared types for the CUS30 queued bus initiator: request word layout,
// FSM encoding and the voice-register window of the CUS30 address map.
package jtcus30_pkg;

    localparam logic [9:0] MMR_BASE = 10'h100;
    localparam int         MMR_SIZE = 64;

    typedef struct packed {
        logic       rnw;
        logic [9:0] addr;
        logic [7:0] data;
    } req_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARB     = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

endpackage

// File: rtl/jtcus30_wrq_fifo.sv
// Synchronous FIFO for queued CUS30 requests; head entry is visible
// combinationally so the bus lines can be driven straight from it.
module jtcus30_wrq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 19
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // NOTE: every output of a combinational block gets a default first so no latch can be inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/jtcus30_wrq.sv
// Queued bus initiator for the CUS30 CPU-side port: buffers client requests,
// arbitrates for the shared bus and issues one access per granted cen slot.
module jtcus30_wrq
    import jtcus30_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int MAXBURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rnw,
    input  logic [9:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic       bcs,
    output logic       brnw,
    output logic [9:0] baddr,
    output logic [7:0] bdout,
    input  logic [7:0] xdin,
    output logic       busy
);

    localparam int         CW    = $clog2(DEPTH) + 1;
    localparam logic [2:0] MAX_B = 3'(MAXBURST);

    req_t          wr_req, head;
    logic          push, pop;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          more_after_pop;

    state_e        state_q, state_d;
    logic [2:0]    burst_q, burst_d;
    logic          cap_q, cap_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;

    assign wr_req = '{rnw: req_rnw, addr: req_addr, data: req_data};
    assign push   = req_valid & ~fifo_full;

    jtcus30_wrq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(req_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wr_req),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A push landing in the same cycle as the pop is already the next head.
    assign more_after_pop = (fifo_count > CW'(1)) | push;

    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        cap_d       = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_ARB;
            end
            ST_ARB: begin
                burst_d = '0;
                if (bus_gnt && cen) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // Losing the grant aborts the slot; the head stays queued for a full retry.
                if (!bus_gnt) begin
                    state_d = ST_ARB;
                end else if (cen) begin
                    pop     = 1'b1;
                    burst_d = burst_q + 3'd1;
                    if (head.rnw) begin
                        state_d = ST_CAPTURE;
                        cap_d   = 1'b1;
                    end else if ((burst_q + 3'd1) < MAX_B && more_after_pop) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_CAPTURE: begin
                // xdin lags the address by one clk, so the first clk here sees the read result.
                if (cap_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = xdin;
                end
                if (cen) begin
                    if (burst_q < MAX_B && !fifo_empty && bus_gnt) state_d = ST_ACCESS;
                    else                                          state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (cen) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            burst_q     <= '0;
            cap_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            cap_q       <= cap_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = ~fifo_full;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign bus_req   = (state_q == ST_ARB) || (state_q == ST_ACCESS) || (state_q == ST_CAPTURE);
    assign bcs       = (state_q == ST_ACCESS) && bus_gnt;
    assign brnw      = (state_q == ST_ACCESS) ? head.rnw  : 1'b1;
    assign baddr     = (state_q == ST_ACCESS) ? head.addr : 10'h000;
    assign bdout     = (state_q == ST_ACCESS) ? head.data : 8'h00;
    assign busy      = ~fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_jtcus30_wrq.sv
// Scoreboard bench for jtcus30_wrq: a CUS30 memory model answers the bus,
// a monitor checks every completed access and response against queued expectations.
module tb_jtcus30_wrq;
    import jtcus30_pkg::*;

    logic       clk, rst_n, cen;
    logic       req_valid, req_ready, req_rnw;
    logic [9:0] req_addr;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       bus_req, bus_gnt, bcs, brnw;
    logic [9:0] baddr;
    logic [7:0] bdout, xdin;
    logic       busy;

    int         n_checks = 0;
    int         n_errors = 0;
    req_t       exp_acc[$];
    logic [7:0] exp_rsp[$];
    int         bursts[$];
    req_t       mon_e;
    int         burst_len, acc_done, bcs_clks, rsp_cnt;
    logic       bus_req_prev;
    bit [7:0]   mem [1024];
    int         wr_total, wr_101;
    int         snap_acc, snap_wr;
    bit         seen;

    jtcus30_wrq #(.DEPTH(8), .MAXBURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rnw   (req_rnw),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .bcs       (bcs),
        .brnw      (brnw),
        .baddr     (baddr),
        .bdout     (bdout),
        .xdin      (xdin),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cen pulses every other clk
    initial begin
        cen = 1'b0;
        forever begin
            @(posedge clk);
            #1 cen = ~cen;
        end
    end

    // CUS30 model: write on the cen that ends a selected write, read data one clk behind the address
    always @(posedge clk) begin
        xdin <= mem[baddr];
        if (cen && bcs && !brnw) begin
            mem[baddr] <= bdout;
            wr_total   <= wr_total + 1;
            if (baddr == 10'h101) wr_101 <= wr_101 + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        burst_len = 0; acc_done = 0; bcs_clks = 0; rsp_cnt = 0; bus_req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bcs) bcs_clks++;
                if (bcs && cen) begin
                    acc_done++;
                    burst_len++;
                    if (exp_acc.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL bus_access: unexpected rnw=%0b addr=0x%0h data=0x%0h, wanted none",
                                 brnw, baddr, bdout);
                    end else begin
                        mon_e = exp_acc.pop_front();
                        check("acc_rnw", brnw, mon_e.rnw);
                        check("acc_addr", baddr, mon_e.addr);
                        if (!mon_e.rnw) check("acc_data", bdout, mon_e.data);
                    end
                end
                if (rsp_valid) begin
                    rsp_cnt++;
                    if (exp_rsp.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL rsp: unexpected response 0x%0h, wanted none", rsp_data);
                    end else begin
                        check("rsp_data", rsp_data, exp_rsp.pop_front());
                    end
                end
                if (bus_req_prev && !bus_req) begin
                    bursts.push_back(burst_len);
                    burst_len = 0;
                end
                bus_req_prev = bus_req;
            end else begin
                bus_req_prev = 1'b0;
                burst_len    = 0;
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic push(input logic rnw, input logic [9:0] a, input logic [7:0] d, input logic [7:0] rd);
        bit ok = 1'b0;
        req_valid = 1'b1; req_rnw = rnw; req_addr = a; req_data = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL push_timeout: addr=0x%0h never accepted, wanted acceptance", a);
            req_valid = 1'b0;
            return;
        end
        exp_acc.push_back('{rnw: rnw, addr: a, data: d});
        if (rnw) exp_rsp.push_back(rd);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = !busy;
        end
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL %s_idle: busy=1 after 400 clks, wanted 0", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bcs(input logic need_cen, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            hit = bcs && (cen || !need_cen);
        end
        if (!hit) begin
            n_checks++; n_errors++;
            $display("FAIL %s: bcs never seen, wanted an access", name);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, wanted completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_rnw = 1'b0; req_addr = '0; req_data = '0; bus_gnt = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_bcs", bcs, 0);
        check("rst_brnw", brnw, 1);
        check("rst_baddr", baddr, 0);
        check("rst_bdout", bdout, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;

        // Single write with grant already high: latency and one-cen bcs pulse
        bus_gnt = 1'b1; bcs_clks = 0;
        push(1'b0, 10'h105, 8'h3C, 8'h00);
        @(negedge clk);
        check("lat_busy", busy, 1);
        check("lat_bus_req_t", bus_req, 0);
        @(negedge clk);
        check("lat_bus_req_t1", bus_req, 1);
        @(posedge clk); #1;
        wait_idle("t1");
        check("t1_bcs_clks", bcs_clks, 2);
        check("t1_freq_reg", mem[10'h105], 8'h3C);

        // Write then read back the same location
        rsp_cnt = 0;
        push(1'b0, 10'h020, 8'hA5, 8'h00);
        push(1'b1, 10'h020, 8'h00, 8'hA5);
        wait_idle("t2");
        check("t2_rsp_cnt", rsp_cnt, 1);
        check("t2_rsp_hold", rsp_data, 8'hA5);

        // Two reads back to back: responses in request order
        rsp_cnt = 0;
        push(1'b1, 10'h105, 8'h00, 8'h3C);
        push(1'b1, 10'h020, 8'h00, 8'hA5);
        wait_idle("t3");
        check("t3_rsp_cnt", rsp_cnt, 2);

        // Fill with grant low, refuse a ninth push, then drain in two bursts of four
        bus_gnt = 1'b0;
        bursts.delete();
        for (int i = 0; i < 8; i++) push(1'b0, 10'(10'h030 + i), 8'(8'h80 + i), 8'h00);
        req_valid = 1'b1; req_rnw = 1'b0; req_addr = 10'h3FF; req_data = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_ready", req_ready, 0);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        bus_gnt = 1'b1;
        wait_bcs(1'b1, "full_first_access");
        @(negedge clk);
        check("ready_after_pop", req_ready, 1);
        @(posedge clk); #1;
        wait_idle("t4");
        check("burst_count", bursts.size(), 2);
        if (bursts.size() == 2) begin
            check("burst0_len", bursts[0], 4);
            check("burst1_len", bursts[1], 4);
        end
        check("t4_last_write", mem[10'h037], 8'h87);
        check("t4_sb_drained", exp_acc.size(), 0);

        // Grant lost mid-ACCESS: bcs falls at once, write retried exactly once
        push(1'b0, 10'h101, 8'h11, 8'h00);
        wait_bcs(1'b0, "drop_access");
        #1 bus_gnt = 1'b0;
        #1 check("drop_bcs", bcs, 0);
        repeat (4) @(negedge clk);
        check("drop_no_write", wr_101, 0);
        check("drop_bus_req", bus_req, 1);
        @(posedge clk);
        #1 bus_gnt = 1'b1;
        wait_idle("t5");
        check("regrant_writes", wr_101, 1);
        check("regrant_ram", mem[10'h101], 8'h11);

        // Reset in the middle of a burst with three entries still queued
        snap_acc = acc_done;
        for (int i = 0; i < 5; i++) push(1'b0, 10'(10'h200 + i), 8'(8'h50 + i), 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (acc_done >= snap_acc + 2);
        end
        check("rst_mid_reached", seen, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_bcs", bcs, 0);
        check("midrst_bus_req", bus_req, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", req_ready, 1);
        exp_acc.delete();
        snap_wr = wr_total;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bcs_clks = 0;
        repeat (20) @(negedge clk);
        check("postrst_bcs_clks", bcs_clks, 0);
        check("postrst_writes", wr_total, snap_wr);
        check("postrst_busy", busy, 0);
        check("postrst_ram_done", mem[10'h201], 8'h51);
        check("postrst_ram_dropped", mem[10'h204], 8'h00);
        check("rsp_sb_drained", exp_rsp.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
